// File: rtl/wb_ext_mem_bridge_if.sv
// wb_ext_mem_bridge_if: Wishbone B3 bus bundle; master drives the request, slave returns data/ack/err/rty
// adr/dat_w/sel/we/cyc/stb/cti/bte: request; dat_r/ack/err/rty: response
interface wb_ext_mem_bridge_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int SW = DW / 8;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_w;
   logic [DW-1:0] dat_r;
   logic [SW-1:0] sel;
   logic          we;
   logic          cyc;
   logic          stb;
   logic [2:0]    cti;
   logic [1:0]    bte;
   logic          ack;
   logic          err;
   logic          rty;
   modport master (output adr, dat_w, sel, we, cyc, stb, cti, bte, input dat_r, ack, err);
   modport slave (input adr, dat_w, sel, we, cyc, stb, cti, bte, output dat_r, ack, err, rty);
endinterface

// File: rtl/wb_ext_mem_bridge.sv
// wb_ext_mem_bridge: registered Wishbone B3 bridge from the interconnect slave port to external memory
// wb_clk_i/wb_rst_i: clock, synchronous active-high reset
// wbs: slave side (from wb_intercon); mem: master side (to mem_* pins), address masked to MEM_SIZE window
module wb_ext_mem_bridge #(
   parameter int          AW       = 32,
   parameter int          DW       = 32,
   parameter logic [31:0] MEM_SIZE = 32'h02000000,
   parameter int          TIMEOUT  = 255
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   wb_ext_mem_bridge_if.slave         wbs,
   wb_ext_mem_bridge_if.master        mem
);
   localparam int SW = DW / 8;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [AW-1:0] MASK = AW'(MEM_SIZE - 32'd1);
   localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t        r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [AW-1:0] r_adr, w_adr;
   logic [DW-1:0] r_dat_w, w_dat_w, r_dat_r, w_dat_r;
   logic [SW-1:0] r_sel, w_sel;
   logic          r_we, w_we, r_cyc, w_cyc, r_stb, w_stb, r_ack, w_ack, r_err, w_err;
   logic [2:0]    r_cti, w_cti;
   logic [1:0]    r_bte, w_bte;
   logic          w_oor;
   assign w_oor = (wbs.adr & ~MASK) != '0;
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_adr   = r_adr;
      w_dat_w = r_dat_w;
      w_dat_r = r_dat_r;
      w_sel   = r_sel;
      w_we    = r_we;
      w_cyc   = r_cyc;
      w_stb   = r_stb;
      w_cti   = r_cti;
      w_bte   = r_bte;
      w_ack   = 1'b0;
      w_err   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (wbs.cyc && wbs.stb) begin
               if (w_oor) begin
                  w_err   = 1'b1;
                  w_cyc   = 1'b0;
                  w_stb   = 1'b0;
                  w_state = RESP;
               end else begin
                  w_adr   = wbs.adr & MASK;
                  w_dat_w = wbs.dat_w;
                  w_sel   = wbs.sel;
                  w_we    = wbs.we;
                  w_cti   = wbs.cti;
                  w_bte   = wbs.bte;
                  w_cyc   = 1'b1;
                  w_stb   = 1'b1;
                  w_cnt   = '0;
                  w_state = BUSY;
               end
            end else begin
               // a held burst cycle is released once the master lets go of cyc
               w_cyc = r_cyc & wbs.cyc;
            end
         end
         BUSY: begin
            if (!wbs.cyc) begin
               w_cyc   = 1'b0;
               w_stb   = 1'b0;
               w_state = IDLE;
            end else if (mem.err || (TIMEOUT != 0 && r_cnt == TLAST && !mem.ack)) begin
               w_err   = 1'b1;
               w_cyc   = 1'b0;
               w_stb   = 1'b0;
               w_state = RESP;
            end else if (mem.ack) begin
               w_ack   = 1'b1;
               w_stb   = 1'b0;
               w_dat_r = r_we ? r_dat_r : mem.dat_r;
               w_state = RESP;
            end else begin
               w_cnt = &r_cnt ? r_cnt : r_cnt + 1'b1;
            end
         end
         RESP: begin
            // r_ack marks a beat that ended with ack; only an incrementing burst keeps the cycle open
            w_cyc   = r_ack && r_cti == 3'b010 && wbs.cyc;
            w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_adr   <= '0;
         r_dat_w <= '0;
         r_dat_r <= '0;
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_cyc   <= 1'b0;
         r_stb   <= 1'b0;
         r_cti   <= '0;
         r_bte   <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_adr   <= w_adr;
         r_dat_w <= w_dat_w;
         r_dat_r <= w_dat_r;
         r_sel   <= w_sel;
         r_we    <= w_we;
         r_cyc   <= w_cyc;
         r_stb   <= w_stb;
         r_cti   <= w_cti;
         r_bte   <= w_bte;
         r_ack   <= w_ack;
         r_err   <= w_err;
      end
   end
   assign wbs.dat_r = r_dat_r;
   assign wbs.ack   = r_ack;
   assign wbs.err   = r_err;
   assign wbs.rty   = 1'b0;
   assign mem.adr   = r_adr;
   assign mem.dat_w = r_dat_w;
   assign mem.sel   = r_sel;
   assign mem.we    = r_we;
   assign mem.cyc   = r_cyc;
   assign mem.stb   = r_stb;
   assign mem.cti   = r_cti;
   assign mem.bte   = r_bte;
endmodule
